// File: rtl/fib_seq_pkg.sv
// fib_seq_pkg: shared FSM state encoding and width helpers for fib_seq_gen.
package fib_seq_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    INIT        = 3'd1,
    COMPUTE     = 3'd2,
    WAIT_GO_LOW = 3'd3,
    DONE        = 3'd4
  } state_t;

  localparam int unsigned FIB_DEF_OUTPUT_WIDTH = 32;

  // Default-width term and carry-extended sum types.
  typedef logic [FIB_DEF_OUTPUT_WIDTH-1:0] term_t;
  typedef logic [FIB_DEF_OUTPUT_WIDTH:0]   sum_t;

  // An adder over two terms needs one extra bit to expose the carry.
  function automatic int unsigned sum_width(input int unsigned term_width);
    return term_width + 32'd1;
  endfunction

endpackage

// File: rtl/fib_seq_datapath.sv
// fib_seq_datapath: operand capture, prev/curr/count registers and the
// carry-extended adder of the recurrence x(i) = x(i-1) + x(i-2).
import fib_seq_pkg::*;

module fib_seq_datapath #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [INPUT_WIDTH-1:0]  n_i,
  input  logic [OUTPUT_WIDTH-1:0] seed0_i,
  input  logic [OUTPUT_WIDTH-1:0] seed1_i,
  output logic [OUTPUT_WIDTH-1:0] prev_o,
  output logic [OUTPUT_WIDTH-1:0] curr_o,
  output logic [OUTPUT_WIDTH-1:0] sum_o,
  output logic                    carry_o,
  output logic                    last_o,
  output logic                    n_zero_o
);

  localparam int SUM_WIDTH = sum_width(OUTPUT_WIDTH);
  localparam logic [INPUT_WIDTH-1:0] CNT_ONE = {{(INPUT_WIDTH-1){1'b0}}, 1'b1};

  logic [INPUT_WIDTH-1:0]  n_q, n_d, count_q, count_d;
  logic [OUTPUT_WIDTH-1:0] seed0_q, seed0_d, seed1_q, seed1_d;
  logic [OUTPUT_WIDTH-1:0] prev_q, prev_d, curr_q, curr_d;
  logic [SUM_WIDTH-1:0]    sum_s;

  assign sum_s    = {1'b0, prev_q} + {1'b0, curr_q};
  assign prev_o   = prev_q;
  assign curr_o   = curr_q;
  assign sum_o    = sum_s[OUTPUT_WIDTH-1:0];
  assign carry_o  = sum_s[OUTPUT_WIDTH];
  // count starts at 1 after INIT, so n<=1 is already the last iteration.
  assign last_o   = (count_q >= n_q);
  assign n_zero_o = (n_q == {INPUT_WIDTH{1'b0}});

  // Next-state: capture operands on start, seed on load, shift on step.
  always_comb begin
    n_d     = n_q;
    seed0_d = seed0_q;
    seed1_d = seed1_q;
    prev_d  = prev_q;
    curr_d  = curr_q;
    count_d = count_q;
    if (start_i) begin
      n_d     = n_i;
      seed0_d = seed0_i;
      seed1_d = seed1_i;
    end else begin
      n_d     = n_q;
    end
    if (load_i) begin
      prev_d  = seed0_q;
      curr_d  = seed1_q;
      count_d = CNT_ONE;
    end else if (step_i) begin
      prev_d  = curr_q;
      curr_d  = sum_s[OUTPUT_WIDTH-1:0];
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q     <= {INPUT_WIDTH{1'b0}};
      count_q <= {INPUT_WIDTH{1'b0}};
      seed0_q <= {OUTPUT_WIDTH{1'b0}};
      seed1_q <= {OUTPUT_WIDTH{1'b0}};
      prev_q  <= {OUTPUT_WIDTH{1'b0}};
      curr_q  <= {OUTPUT_WIDTH{1'b0}};
    end else begin
      n_q     <= n_d;
      count_q <= count_d;
      seed0_q <= seed0_d;
      seed1_q <= seed1_d;
      prev_q  <= prev_d;
      curr_q  <= curr_d;
    end
  end

endmodule

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: n-th term of a seeded second-order additive recurrence with a
// go/done handshake, busy flag and sticky overflow with early termination.
// Optional macro FIB_SEQ_STREAM_EN adds a term/term_valid stream of x(2)..x(n).
import fib_seq_pkg::*;

module fib_seq_gen #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [INPUT_WIDTH-1:0]  n,
  input  logic [OUTPUT_WIDTH-1:0] seed0,
  input  logic [OUTPUT_WIDTH-1:0] seed1,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    done,
`ifdef FIB_SEQ_STREAM_EN
  output logic [OUTPUT_WIDTH-1:0] term,
  output logic                    term_valid,
`endif
  output logic                    busy
);

  state_t state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] result_q, result_d;
  logic overflow_q, overflow_d, done_q, done_d, busy_q, busy_d;
  logic start_s, load_s, step_s, finish_s;
  logic [OUTPUT_WIDTH-1:0] prev_s, curr_s, sum_s;
  logic carry_s, last_s, n_zero_s;

  fib_seq_datapath #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_datapath (
    .clk_i   (clk),
    .rst_ni  (rst),
    .start_i (start_s),
    .load_i  (load_s),
    .step_i  (step_s),
    .n_i     (n),
    .seed0_i (seed0),
    .seed1_i (seed1),
    .prev_o  (prev_s),
    .curr_o  (curr_s),
    .sum_o   (sum_s),
    .carry_o (carry_s),
    .last_o  (last_s),
    .n_zero_o(n_zero_s)
  );

  // FSM next-state, datapath controls and next values of the handshake outputs.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    start_s    = 1'b0;
    load_s     = 1'b0;
    step_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          start_s    = 1'b1;
          state_d    = INIT;
          done_d     = 1'b0;
          overflow_d = 1'b0;
        end else begin
          state_d    = state_q;
        end
      end
      INIT: begin
        load_s  = 1'b1;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        if (last_s) begin
          // With no additions prev still holds seed0, curr holds seed1.
          finish_s = 1'b1;
          result_d = n_zero_s ? prev_s : curr_s;
        end else begin
          step_s = 1'b1;
          if (carry_s) begin
            finish_s   = 1'b1;
            overflow_d = 1'b1;
            result_d   = sum_s;
          end else begin
            finish_s   = 1'b0;
          end
        end
        if (finish_s) begin
          // done may only rise after a cycle in which go was low.
          state_d = go ? WAIT_GO_LOW : DONE;
          done_d  = !go;
        end else begin
          state_d = COMPUTE;
        end
      end
      WAIT_GO_LOW: begin
        if (!go) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_GO_LOW;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == INIT) || (state_d == COMPUTE);
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      result_q   <= {OUTPUT_WIDTH{1'b0}};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign busy     = busy_q;

`ifdef FIB_SEQ_STREAM_EN
  logic [OUTPUT_WIDTH-1:0] term_q;
  logic                    term_valid_q;

  // Stream every newly computed term, including a truncated overflowing one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      term_q       <= {OUTPUT_WIDTH{1'b0}};
      term_valid_q <= 1'b0;
    end else begin
      term_q       <= step_s ? sum_s : term_q;
      term_valid_q <= step_s;
    end
  end

  assign term       = term_q;
  assign term_valid = term_valid_q;
`endif

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb_fib_seq_gen: randomized scoreboard bench for fib_seq_gen with an
// arithmetic reference model of the seeded recurrence.
`timescale 1ns/1ps

module tb_fib_seq_gen;

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    int          done_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go  = 1'b0;
  logic [5:0]  n   = 6'd0;
  logic [31:0] seed0 = 32'd0, seed1 = 32'd0;
  logic [31:0] result;
  logic        overflow, done, busy;
`ifdef FIB_SEQ_STREAM_EN
  logic [31:0] term;
  logic        term_valid;
  logic [31:0] tq[$];
`endif

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic done_prev = 1'b0;

  fib_seq_gen #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n), .seed0(seed0), .seed1(seed1),
    .result(result), .overflow(overflow), .done(done),
`ifdef FIB_SEQ_STREAM_EN
    .term(term), .term_valid(term_valid),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: iterate the recurrence with 64-bit arithmetic, stop at the
  // first sum that no longer fits in 32 bits.
  task automatic model(input int nn, input logic [31:0] s0, input logic [31:0] s1,
                       output logic [31:0] r, output logic ov, output int lat);
    longint unsigned a, b, s;
    a = s0; b = s1; ov = 1'b0;
    r = (nn == 0) ? s0 : s1;
    lat = (nn <= 1) ? 2 : nn + 1;
    for (int i = 2; i <= nn; i++) begin
      s = a + b;
`ifdef FIB_SEQ_STREAM_EN
      tq.push_back(s[31:0]);
`endif
      r = s[31:0];
      if (s > 64'h0000_0000_FFFF_FFFF) begin
        ov = 1'b1;
        lat = i;
        break;
      end
      a = b;
      b = s;
    end
  endtask

  // Monitor: on every rising done compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.result);
          chk("overflow", overflow, e.ovf);
          chk("done_latency_edge", cyc, e.done_edge);
          chk("busy_at_done", busy, 0);
        end
      end
`ifdef FIB_SEQ_STREAM_EN
      if (term_valid) begin
        if (tq.size() == 0) chk("unexpected_term", 1, 0);
        else chk("term", term, tq.pop_front());
      end
`endif
    end
    done_prev <= done;
  end

  task automatic start_run(input int nn, input logic [31:0] s0, input logic [31:0] s1,
                           input int hold, input int glitch);
    logic [31:0] r;
    logic ov;
    int lat;
    exp_t e;
    model(nn, s0, s1, r, ov, lat);
    e.result    = r;
    e.ovf       = ov;
    e.done_edge = cyc + 1 + ((hold > lat) ? hold : lat);
    sb.push_back(e);
    n = nn[5:0]; seed0 = s0; seed1 = s1; go = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_after_accept", busy, 1);
        chk("done_cleared_on_accept", done, 0);
      end
    end
    go = 1'b0;
    if (glitch > 0) begin
      repeat (glitch) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nn, kind, hold;
    logic [31:0] s0, s1;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed runs: Fibonacci, Lucas, n=0/1, last fitting term, first overflow.
    start_run(10, 32'd0, 32'd1, 1, 0); wait_done();
    start_run(5,  32'd2, 32'd1, 1, 0); wait_done();
    start_run(0,  32'd2, 32'd1, 1, 0); wait_done();
    start_run(1,  32'd2, 32'd1, 1, 0); wait_done();
    start_run(47, 32'd0, 32'd1, 1, 0); wait_done();
    start_run(48, 32'd0, 32'd1, 1, 0); wait_done();
    start_run(6,  32'd0, 32'd1, 1, 0); wait_done();
    start_run(3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0); wait_done();
    // go held past completion, then immediate restart from DONE.
    start_run(4,  32'd0, 32'd1, 9, 0); wait_done();
    start_run(7,  32'd3, 32'd4, 1, 0); wait_done();
    // go pulsed mid-computation must be ignored.
    start_run(20, 32'd0, 32'd1, 1, 5); wait_done();

    // Reset during a run aborts it with no done.
    start_run(30, 32'd0, 32'd1, 1, 0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
`ifdef FIB_SEQ_STREAM_EN
    chk("midrst_term_valid", term_valid, 0);
    chk("midrst_term", term, 0);
    tq.delete();
`endif
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_run(12, 32'd0, 32'd1, 1, 0); wait_done();

    // Randomized runs.
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin nn = $urandom_range(0, 40); s0 = $urandom_range(0, 5); s1 = $urandom_range(0, 5); end
        1: begin nn = $urandom_range(0, 12); s0 = $urandom; s1 = $urandom; end
        2: begin nn = $urandom_range(0, 4);  s0 = 32'hFFFF_FFFF; s1 = 32'hFFFF_FFFF; end
        default: begin nn = $urandom_range(40, 63); s0 = 32'd0; s1 = 32'd1; end
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 1;
      start_run(nn, s0, s1, hold, 0);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
`ifdef FIB_SEQ_STREAM_EN
    chk("term_queue_empty", tq.size(), 0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
